axi_lite_2_hs_arb: RTL and testbench

//  Parametrised AXI4-Lite slave to simple handshake (HS) bridge; successor of the single-FSM bridge.

---
 rtl/axi_lite_2_hs_arb_if.sv | 48 ++++
 rtl/axi_lite_2_hs_arb.sv | 217 +++++++++++++++++++++
 tb/tb_axi_lite_2_hs_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_2_hs_arb_if.sv
// Signal bundle for axi_lite_2_hs_arb: the AXI4-Lite slave channels plus the handshake (HS) master side.
// The slave modport is the bridge's view; the master modport is the view of the interconnect/peripheral.
interface axi_lite_2_hs_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              arvalid_i;
  logic              arready_o;
  logic [ADDR_W-1:0] araddr_i;
  logic              rvalid_o;
  logic              rready_i;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              awvalid_i;
  logic              awready_o;
  logic [ADDR_W-1:0] awaddr_i;
  logic              wvalid_i;
  logic              wready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              bvalid_o;
  logic              bready_i;
  logic [1:0]        bresp_o;
  logic              hs_read_o;
  logic              hs_write_o;
  logic [ADDR_W-1:0] hs_addr_o;
  logic [DATA_W-1:0] hs_data_o;
  logic [STRB_W-1:0] byte_select_o;
  logic              hs_ready_i;
  logic              hs_err_i;
  logic [DATA_W-1:0] hs_data_i;

  modport slave (
    input  arvalid_i, araddr_i, rready_i, awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i,
           bready_i, hs_ready_i, hs_err_i, hs_data_i,
    output arready_o, rvalid_o, rdata_o, rresp_o, awready_o, wready_o, bvalid_o, bresp_o,
           hs_read_o, hs_write_o, hs_addr_o, hs_data_o, byte_select_o
  );

  modport master (
    output arvalid_i, araddr_i, rready_i, awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i,
           bready_i, hs_ready_i, hs_err_i, hs_data_i,
    input  arready_o, rvalid_o, rdata_o, rresp_o, awready_o, wready_o, bvalid_o, bresp_o,
           hs_read_o, hs_write_o, hs_addr_o, hs_data_o, byte_select_o
  );
endinterface

// File: rtl/axi_lite_2_hs_arb.sv
// AXI4-Lite slave to handshake bridge with independent AR/AW/W holding registers and round-robin
// read/write arbitration. Define AXI2HS_TIMEOUT_EN to abort HS accesses after TIMEOUT_CYC strobe cycles.
module axi_lite_2_hs_arb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                clk_i,
  input logic                rst_i,
  axi_lite_2_hs_arb_if.slave bus
);
  localparam int         STRB_W      = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic       GRANT_RD    = 1'b0;
  localparam logic       GRANT_WR    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HS_RD  = 3'd1,
    ST_R_RESP = 3'd2,
    ST_HS_WR  = 3'd3,
    ST_B_RESP = 3'd4
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic              last_grant_r;
  logic              last_grant_nxt_s;
  logic              ar_full_r;
  logic              aw_full_r;
  logic              w_full_r;
  logic [ADDR_W-1:0] ar_addr_r;
  logic [ADDR_W-1:0] aw_addr_r;
  logic [DATA_W-1:0] w_data_r;
  logic [STRB_W-1:0] w_strb_r;
  logic [DATA_W-1:0] rdata_r;
  logic [1:0]        rresp_r;
  logic [1:0]        bresp_r;
  logic              rvalid_r;
  logic              bvalid_r;
  logic              hs_read_r;
  logic              hs_write_r;

  logic ar_hs_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic rd_pend_s;
  logic wr_pend_s;
  logic hs_busy_s;
  logic hs_done_s;
  logic tmo_hit_s;
  logic err_s;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
    $fatal(1, "axi_lite_2_hs_arb: TIMEOUT_CYC must be >= 1");
  end

  assign ar_hs_s   = bus.arvalid_i & ~ar_full_r;
  assign aw_hs_s   = bus.awvalid_i & ~aw_full_r;
  assign w_hs_s    = bus.wvalid_i & ~w_full_r;
  assign rd_pend_s = ar_full_r;
  assign wr_pend_s = aw_full_r & w_full_r;
  assign hs_busy_s = (state_r == ST_HS_RD) | (state_r == ST_HS_WR);
  assign hs_done_s = hs_busy_s & (bus.hs_ready_i | tmo_hit_s);
  assign err_s     = bus.hs_err_i | tmo_hit_s;

`ifdef AXI2HS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Strobe-cycle counter, zero outside the HS states so each access starts from 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_r <= '0;
    end else if (hs_busy_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // A real hs_ready_i in the last allowed cycle takes precedence over the abort.
  assign tmo_hit_s = hs_busy_s & ~bus.hs_ready_i & (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and round-robin grant decision.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_pend_s && wr_pend_s) begin
          if (last_grant_r == GRANT_WR) begin
            state_nxt_s      = ST_HS_RD;
            last_grant_nxt_s = GRANT_RD;
          end else begin
            state_nxt_s      = ST_HS_WR;
            last_grant_nxt_s = GRANT_WR;
          end
        end else if (rd_pend_s) begin
          state_nxt_s      = ST_HS_RD;
          last_grant_nxt_s = GRANT_RD;
        end else if (wr_pend_s) begin
          state_nxt_s      = ST_HS_WR;
          last_grant_nxt_s = GRANT_WR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HS_RD: begin
        if (hs_done_s) state_nxt_s = ST_R_RESP;
        else           state_nxt_s = ST_HS_RD;
      end
      ST_R_RESP: begin
        if (bus.rready_i) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_R_RESP;
      end
      ST_HS_WR: begin
        if (hs_done_s) state_nxt_s = ST_B_RESP;
        else           state_nxt_s = ST_HS_WR;
      end
      ST_B_RESP: begin
        if (bus.bready_i) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_B_RESP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, grant history and the state-decoded strobe/valid output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GRANT_WR;
      hs_read_r    <= 1'b0;
      hs_write_r   <= 1'b0;
      rvalid_r     <= 1'b0;
      bvalid_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      hs_read_r    <= (state_nxt_s == ST_HS_RD);
      hs_write_r   <= (state_nxt_s == ST_HS_WR);
      rvalid_r     <= (state_nxt_s == ST_R_RESP);
      bvalid_r     <= (state_nxt_s == ST_B_RESP);
    end
  end

  // Per-channel holding registers; a flag can only set while empty, so set and clear never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_full_r <= 1'b0;
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      ar_addr_r <= '0;
      aw_addr_r <= '0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
    end else begin
      if (ar_hs_s) begin
        ar_full_r <= 1'b1;
        ar_addr_r <= bus.araddr_i;
      end else if ((state_r == ST_HS_RD) && hs_done_s) begin
        ar_full_r <= 1'b0;
      end
      if (aw_hs_s) begin
        aw_full_r <= 1'b1;
        aw_addr_r <= bus.awaddr_i;
      end else if ((state_r == ST_HS_WR) && hs_done_s) begin
        aw_full_r <= 1'b0;
      end
      if (w_hs_s) begin
        w_full_r <= 1'b1;
        w_data_r <= bus.wdata_i;
        w_strb_r <= bus.wstrb_i;
      end else if ((state_r == ST_HS_WR) && hs_done_s) begin
        w_full_r <= 1'b0;
      end
    end
  end

  // Response data captured at HS completion and held through the response state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_r <= '0;
      rresp_r <= RESP_OKAY;
      bresp_r <= RESP_OKAY;
    end else begin
      if ((state_r == ST_HS_RD) && hs_done_s) begin
        rdata_r <= tmo_hit_s ? '0 : bus.hs_data_i;
        rresp_r <= err_s ? RESP_SLVERR : RESP_OKAY;
      end
      if ((state_r == ST_HS_WR) && hs_done_s) begin
        bresp_r <= err_s ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign bus.arready_o     = ~ar_full_r & ~rst_i;
  assign bus.awready_o     = ~aw_full_r & ~rst_i;
  assign bus.wready_o      = ~w_full_r & ~rst_i;
  assign bus.rvalid_o      = rvalid_r;
  assign bus.rdata_o       = rdata_r;
  assign bus.rresp_o       = rresp_r;
  assign bus.bvalid_o      = bvalid_r;
  assign bus.bresp_o       = bresp_r;
  assign bus.hs_read_o     = hs_read_r;
  assign bus.hs_write_o    = hs_write_r;
  assign bus.hs_addr_o     = hs_read_r ? ar_addr_r : aw_addr_r;
  assign bus.hs_data_o     = w_data_r;
  assign bus.byte_select_o = w_strb_r;
endmodule

// File: tb/tb_axi_lite_2_hs_arb.sv
// Self-checking bench for axi_lite_2_hs_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model (expected addresses, data, responses, grant order).
module tb_axi_lite_2_hs_arb;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   ref_last_wr;

  axi_lite_2_hs_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_2_hs_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arvalid_i = 1'b0; bus.araddr_i = 32'h0; bus.rready_i = 1'b0;
    bus.awvalid_i = 1'b0; bus.awaddr_i = 32'h0; bus.wvalid_i  = 1'b0;
    bus.wdata_i   = 32'h0; bus.wstrb_i = 4'h0;  bus.bready_i  = 1'b0;
    bus.hs_ready_i = 1'b0; bus.hs_err_i = 1'b0; bus.hs_data_i = 32'h0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Acts as the HS slave for one access and then as the AXI master collecting the response.
  task automatic serve_txn(input bit exp_wr, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_strb, input int wait_cyc, input logic [31:0] rdat,
                           input bit err, input int resp_dly, input string tag);
    logic [1:0] exp_kind;
    logic [1:0] exp_resp;
    int n;
    exp_kind = exp_wr ? 2'b10 : 2'b01;
    exp_resp = err ? 2'b10 : 2'b00;
    n = 0;
    while (!(bus.hs_read_o || bus.hs_write_o) && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if ({bus.hs_write_o, bus.hs_read_o} !== exp_kind) begin
      errors++; $display("FAIL %s strobe: got %b expected %b", tag, {bus.hs_write_o, bus.hs_read_o}, exp_kind);
    end
    checks++;
    if (bus.hs_addr_o !== exp_addr) begin
      errors++; $display("FAIL %s hs_addr: got %h expected %h", tag, bus.hs_addr_o, exp_addr);
    end
    if (exp_wr) begin
      checks++;
      if ({bus.hs_data_o, bus.byte_select_o} !== {exp_wdata, exp_strb}) begin
        errors++; $display("FAIL %s hs_data/strb: got %h/%b expected %h/%b", tag, bus.hs_data_o, bus.byte_select_o, exp_wdata, exp_strb);
      end
    end
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      checks++;
      if (({bus.hs_write_o, bus.hs_read_o} !== exp_kind) || (bus.hs_addr_o !== exp_addr)) begin
        errors++; $display("FAIL %s strobe_hold: got %b/%h expected %b/%h", tag, {bus.hs_write_o, bus.hs_read_o}, bus.hs_addr_o, exp_kind, exp_addr);
      end
    end
    bus.hs_ready_i = 1'b1; bus.hs_err_i = err; bus.hs_data_i = rdat;
    tick();
    bus.hs_ready_i = 1'b0; bus.hs_err_i = 1'b0; bus.hs_data_i = $urandom();
    for (int i = 0; i <= resp_dly; i++) begin
      checks++;
      if (exp_wr) begin
        if ({bus.bvalid_o, bus.bresp_o, bus.rvalid_o, bus.hs_write_o} !== {1'b1, exp_resp, 2'b00}) begin
          errors++; $display("FAIL %s b_resp: got bvalid %b bresp %b rvalid %b hs_write %b expected 1 %b 0 0", tag, bus.bvalid_o, bus.bresp_o, bus.rvalid_o, bus.hs_write_o, exp_resp);
        end
      end else begin
        if ({bus.rvalid_o, bus.rresp_o, bus.rdata_o, bus.bvalid_o, bus.hs_read_o} !== {1'b1, exp_resp, rdat, 2'b00}) begin
          errors++; $display("FAIL %s r_resp: got rvalid %b rresp %b rdata %h hs_read %b expected 1 %b %h 0", tag, bus.rvalid_o, bus.rresp_o, bus.rdata_o, bus.hs_read_o, exp_resp, rdat);
        end
      end
      if (i == resp_dly) begin
        bus.rready_i = !exp_wr;
        bus.bready_i = exp_wr;
      end
      tick();
    end
    bus.rready_i = 1'b0; bus.bready_i = 1'b0;
    checks++;
    if ({bus.rvalid_o, bus.bvalid_o} !== 2'b00) begin
      errors++; $display("FAIL %s resp_done: got rvalid %b bvalid %b expected 0 0", tag, bus.rvalid_o, bus.bvalid_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.arvalid_i = 1'b1; bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.arready_o, bus.awready_o, bus.wready_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b expected 000", {bus.arready_o, bus.awready_o, bus.wready_o});
    end
    checks++;
    if ({bus.rvalid_o, bus.bvalid_o, bus.hs_read_o, bus.hs_write_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", {bus.rvalid_o, bus.bvalid_o, bus.hs_read_o, bus.hs_write_o});
    end
    checks++;
    if ({bus.rdata_o, bus.rresp_o, bus.bresp_o, bus.hs_addr_o, bus.hs_data_o, bus.byte_select_o} !== 104'h0) begin
      errors++; $display("FAIL reset_data: got rdata %h hs_addr %h hs_data %h expected 0", bus.rdata_o, bus.hs_addr_o, bus.hs_data_o);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.arready_o, bus.awready_o, bus.wready_o} !== 3'b111) begin
      errors++; $display("FAIL post_reset_ready: got %b expected 111", {bus.arready_o, bus.awready_o, bus.wready_o});
    end
  endtask

  task automatic test_zero_wait_read();
    bus.arvalid_i = 1'b1; bus.araddr_i = 32'h10;
    checks++;
    if (bus.arready_o !== 1'b1) begin errors++; $display("FAIL zw_arready: got %b expected 1", bus.arready_o); end
    tick();
    bus.arvalid_i = 1'b0;
    checks++;
    if ({bus.hs_read_o, bus.rvalid_o} !== 2'b00) begin
      errors++; $display("FAIL zw_early: got hs_read %b rvalid %b expected 0 0", bus.hs_read_o, bus.rvalid_o);
    end
    tick();
    checks++;
    if ({bus.hs_read_o, bus.hs_addr_o, bus.rvalid_o} !== {1'b1, 32'h10, 1'b0}) begin
      errors++; $display("FAIL zw_strobe: got hs_read %b addr %h rvalid %b expected 1 00000010 0", bus.hs_read_o, bus.hs_addr_o, bus.rvalid_o);
    end
    bus.hs_ready_i = 1'b1; bus.hs_data_i = 32'hCAFE0001;
    tick();
    bus.hs_ready_i = 1'b0; bus.hs_data_i = 32'h0;
    checks++;
    if ({bus.rvalid_o, bus.rdata_o, bus.rresp_o, bus.hs_read_o} !== {1'b1, 32'hCAFE0001, 2'b00, 1'b0}) begin
      errors++; $display("FAIL zw_rvalid: got rvalid %b rdata %h rresp %b hs_read %b expected 1 cafe0001 00 0", bus.rvalid_o, bus.rdata_o, bus.rresp_o, bus.hs_read_o);
    end
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
    checks++;
    if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL zw_rdone: got %b expected 0", bus.rvalid_o); end
  endtask

  task automatic test_w_before_aw();
    bus.wvalid_i = 1'b1; bus.wdata_i = 32'hA5A5A5A5; bus.wstrb_i = 4'b0011;
    tick();
    bus.wvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.wready_o, bus.hs_write_o} !== 2'b00) begin
        errors++; $display("FAIL wfirst_wait: got wready %b hs_write %b expected 0 0", bus.wready_o, bus.hs_write_o);
      end
      tick();
    end
    bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h20;
    tick();
    bus.awvalid_i = 1'b0;
    serve_txn(1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011, 0, 32'h0, 1'b0, 0, "w_before_aw");
  endtask

  task automatic test_tie_arbitration();
    pulse_reset();
    bus.arvalid_i = 1'b1; bus.araddr_i = 32'h30;
    bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h40;
    bus.wvalid_i  = 1'b1; bus.wdata_i  = 32'h11223344; bus.wstrb_i = 4'hF;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({bus.hs_write_o, bus.hs_read_o, bus.hs_addr_o} !== {2'b01, 32'h30}) begin
      errors++; $display("FAIL tie1_first: got %b addr %h expected 01 addr 00000030", {bus.hs_write_o, bus.hs_read_o}, bus.hs_addr_o);
    end
    bus.hs_ready_i = 1'b1; bus.hs_data_i = 32'h0BAD0030;
    tick();
    bus.hs_ready_i = 1'b0;
    bus.arvalid_i = 1'b1; bus.araddr_i = 32'h34;
    checks++;
    if ({bus.rvalid_o, bus.rdata_o, bus.arready_o} !== {1'b1, 32'h0BAD0030, 1'b1}) begin
      errors++; $display("FAIL tie1_resp: got rvalid %b rdata %h arready %b expected 1 0bad0030 1", bus.rvalid_o, bus.rdata_o, bus.arready_o);
    end
    tick();
    bus.arvalid_i = 1'b0; bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
    serve_txn(1'b1, 32'h40, 32'h11223344, 4'hF, 1, 32'h0, 1'b0, 0, "tie2_write_first");
    serve_txn(1'b0, 32'h34, 32'h0, 4'h0, 0, 32'h55667788, 1'b0, 0, "tie2_read_second");
  endtask

  task automatic test_slverr();
    bus.arvalid_i = 1'b1; bus.araddr_i = 32'h70;
    tick();
    bus.arvalid_i = 1'b0;
    serve_txn(1'b0, 32'h70, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b1, 0, "slverr_read");
    bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h74;
    bus.wvalid_i  = 1'b1; bus.wdata_i  = 32'h0000FFFF; bus.wstrb_i = 4'b1100;
    tick();
    idle_inputs();
    serve_txn(1'b1, 32'h74, 32'h0000FFFF, 4'b1100, 2, 32'h0, 1'b1, 1, "slverr_write");
  endtask

  task automatic test_rready_backpressure();
    bus.arvalid_i = 1'b1; bus.araddr_i = 32'h50;
    tick();
    bus.arvalid_i = 1'b0;
    tick();
    bus.hs_ready_i = 1'b1; bus.hs_data_i = 32'h5050A0A0;
    tick();
    bus.hs_ready_i = 1'b0; bus.hs_data_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rvalid_o, bus.rdata_o, bus.rresp_o, bus.hs_read_o} !== {1'b1, 32'h5050A0A0, 2'b00, 1'b0}) begin
        errors++; $display("FAIL bp_hold: got rvalid %b rdata %h hs_read %b expected 1 5050a0a0 0", bus.rvalid_o, bus.rdata_o, bus.hs_read_o);
      end
      bus.arvalid_i = (i == 1); bus.araddr_i = 32'h54;
      if (i == 1) begin
        checks++;
        if (bus.arready_o !== 1'b1) begin errors++; $display("FAIL bp_arready: got %b expected 1", bus.arready_o); end
      end
      tick();
    end
    bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
    serve_txn(1'b0, 32'h54, 32'h0, 4'h0, 0, 32'h54545454, 1'b0, 0, "bp_second_read");
  endtask

  task automatic test_timeout();
    int n;
    bus.arvalid_i = 1'b1; bus.araddr_i = 32'h60;
    tick();
    bus.arvalid_i = 1'b0;
    tick();
    n = 0;
    while (bus.hs_read_o && n < 40) begin
      n++;
      tick();
    end
`ifdef AXI2HS_TIMEOUT_EN
    checks++;
    if (n !== TIMEOUT_CYC) begin errors++; $display("FAIL tmo_strobe_len: got %0d expected %0d", n, TIMEOUT_CYC); end
    checks++;
    if ({bus.rvalid_o, bus.rresp_o, bus.rdata_o} !== {1'b1, 2'b10, 32'h0}) begin
      errors++; $display("FAIL tmo_resp: got rvalid %b rresp %b rdata %h expected 1 10 0", bus.rvalid_o, bus.rresp_o, bus.rdata_o);
    end
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
`else
    checks++;
    if (n !== 40) begin errors++; $display("FAIL notmo_strobe_len: got %0d expected 40", n); end
    bus.hs_ready_i = 1'b1; bus.hs_data_i = 32'h60606060;
    tick();
    bus.hs_ready_i = 1'b0;
    checks++;
    if ({bus.rvalid_o, bus.rresp_o, bus.rdata_o} !== {1'b1, 2'b00, 32'h60606060}) begin
      errors++; $display("FAIL notmo_resp: got rvalid %b rresp %b rdata %h expected 1 00 60606060", bus.rvalid_o, bus.rresp_o, bus.rdata_o);
    end
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
`endif
  endtask

  task automatic test_reset_abort();
    int n;
    bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h80;
    bus.wvalid_i  = 1'b1; bus.wdata_i  = 32'h80808080; bus.wstrb_i = 4'hF;
    tick();
    idle_inputs();
    n = 0;
    while (!bus.hs_write_o && n < 8) begin tick(); n++; end
    checks++;
    if (bus.hs_write_o !== 1'b1) begin errors++; $display("FAIL abort_start: got %b expected 1", bus.hs_write_o); end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.hs_write_o, bus.bvalid_o, bus.awready_o, bus.wready_o} !== 4'b0000) begin
      errors++; $display("FAIL abort_in_reset: got %b expected 0000", {bus.hs_write_o, bus.bvalid_o, bus.awready_o, bus.wready_o});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.hs_write_o, bus.hs_read_o, bus.bvalid_o, bus.awready_o, bus.wready_o} !== 5'b00011) begin
        errors++; $display("FAIL abort_after: got %b expected 00011", {bus.hs_write_o, bus.hs_read_o, bus.bvalid_o, bus.awready_o, bus.wready_o});
      end
    end
  endtask

  task automatic test_random();
    pulse_reset();
    ref_last_wr = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int         kind;
      int         gap;
      bit         w_first;
      logic [31:0] ra, wa, wd, rd;
      logic [3:0] st;
      bit         er, ew;
      kind = $urandom_range(2, 0);
      ra = $urandom() & 32'hFFFF_FFFC; wa = $urandom() & 32'hFFFF_FFFC;
      wd = $urandom(); rd = $urandom(); st = 4'($urandom_range(15, 0));
      er = 1'($urandom_range(1, 0)); ew = 1'($urandom_range(1, 0));
      if (kind == 0) begin
        bus.arvalid_i = 1'b1; bus.araddr_i = ra;
        checks++;
        if (bus.arready_o !== 1'b1) begin errors++; $display("FAIL rand_arready it %0d: got %b expected 1", it, bus.arready_o); end
        tick();
        bus.arvalid_i = 1'b0;
        serve_txn(1'b0, ra, 32'h0, 4'h0, $urandom_range(3, 0), rd, er, $urandom_range(2, 0), "rand_rd");
        ref_last_wr = 1'b0;
      end else if (kind == 1) begin
        w_first = 1'($urandom_range(1, 0));
        gap = $urandom_range(3, 0);
        bus.awaddr_i = wa; bus.wdata_i = wd; bus.wstrb_i = st;
        bus.awvalid_i = (gap == 0) || !w_first;
        bus.wvalid_i  = (gap == 0) || w_first;
        checks++;
        if ({bus.awready_o, bus.wready_o} !== 2'b11) begin
          errors++; $display("FAIL rand_wready it %0d: got %b expected 11", it, {bus.awready_o, bus.wready_o});
        end
        tick();
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        if (gap != 0) begin
          repeat (gap - 1) tick();
          bus.awvalid_i = w_first; bus.wvalid_i = !w_first;
          tick();
          bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        end
        serve_txn(1'b1, wa, wd, st, $urandom_range(3, 0), 32'h0, ew, $urandom_range(2, 0), "rand_wr");
        ref_last_wr = 1'b1;
      end else begin
        bus.arvalid_i = 1'b1; bus.araddr_i = ra;
        bus.awvalid_i = 1'b1; bus.awaddr_i = wa;
        bus.wvalid_i  = 1'b1; bus.wdata_i  = wd; bus.wstrb_i = st;
        tick();
        bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        if (ref_last_wr) begin
          serve_txn(1'b0, ra, 32'h0, 4'h0, $urandom_range(2, 0), rd, er, $urandom_range(2, 0), "rand_tie_rd");
          serve_txn(1'b1, wa, wd, st, $urandom_range(2, 0), 32'h0, ew, $urandom_range(2, 0), "rand_tie_wr");
        end else begin
          serve_txn(1'b1, wa, wd, st, $urandom_range(2, 0), 32'h0, ew, $urandom_range(2, 0), "rand_tie_wr");
          serve_txn(1'b0, ra, 32'h0, 4'h0, $urandom_range(2, 0), rd, er, $urandom_range(2, 0), "rand_tie_rd");
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_w_before_aw();
    test_tie_arbitration();
    test_slverr();
    test_rready_backpressure();
    test_timeout();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
